pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank_pkg.sv | 23 ++
 rtl/pwm_bank_channel.sv | 21 ++
 rtl/pwm_bank.sv | 90 +++++++++
 tb/tb_pwm_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared widths, edge pair type and edge calculation for pwm_bank.
package pwm_bank_pkg;
    localparam int DEF_DEPTH = 249;
    localparam int CNT_W     = 9;
    localparam int PHASE_W   = 8;
    localparam int T         = 2 ** CNT_W;
    localparam int PS_SHIFT  = CNT_W - PHASE_W;

    typedef struct packed {
        logic [CNT_W-1:0] rise;
        logic [CNT_W-1:0] fall;
    } edge_t;

    localparam edge_t EDGE_OFF = '{rise: '0, fall: '0};

    // PW = 0 yields rise == fall, the always-low marker.
    function automatic edge_t calc_edge(input logic [PHASE_W-1:0] phase, input logic [CNT_W-1:0] pw);
        int ps;
        ps = int'(phase) << PS_SHIFT;
        calc_edge.rise = CNT_W'((ps - int'(pw) / 2 + T) % T);
        calc_edge.fall = CNT_W'((ps + (int'(pw) + 1) / 2) % T);
    endfunction
endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_bank_channel: cyclic [rise, fall) compare against the carrier, registered and gated.
module pwm_bank_channel
    import pwm_bank_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_time_cnt,
    input  edge_t            i_edge,
    input  logic             i_en,
    output logic             o_pwm
);
    logic w_hit;

    assign w_hit = (i_edge.rise < i_edge.fall) ? (i_time_cnt >= i_edge.rise && i_time_cnt < i_edge.fall) :
                   (i_edge.rise > i_edge.fall) ? (i_time_cnt >= i_edge.rise || i_time_cnt < i_edge.fall) :
                   1'b0;

    always_ff @(posedge i_clk) begin
        o_pwm <= i_rst ? 1'b0 : (i_en && w_hit);
    end
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: double-buffered bank of centre-aligned PWM channels.
// Define PWM_BANK_FRAME_CHECK_EN to enable the sticky FRAME_ERR under/overrun flag.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int CNT_WIDTH   = CNT_W,
    parameter int PHASE_WIDTH = PHASE_W
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CNT_WIDTH-1:0]   TIME_CNT,
    input  logic                   UPDATE,
    input  logic                   DIN_VALID,
    input  logic [CNT_WIDTH-1:0]   PULSE_WIDTH,
    input  logic [PHASE_WIDTH-1:0] PHASE,
    input  logic                   OUTPUT_EN,
    output logic                   PWM_OUT [DEPTH],
    output logic                   DOUT_VALID,
    output logic                   FRAME_ERR
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] r_wr_idx;
    logic             r_complete;
    logic             r_dout_valid;
    edge_t            r_shadow [DEPTH];
    edge_t            r_active [DEPTH];
    edge_t            w_edge;
    logic             w_wr;
    logic             w_last;
    logic             w_apply;

    assign w_edge     = calc_edge(PHASE, PULSE_WIDTH);
    assign w_wr       = DIN_VALID && !r_complete;
    assign w_last     = r_wr_idx == IDX_W'(DEPTH - 1);
    assign w_apply    = UPDATE && r_complete;
    assign DOUT_VALID = r_dout_valid;

    // A last write coinciding with UPDATE sets complete only after this edge, so it waits for the next UPDATE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_idx     <= '0;
            r_complete   <= 1'b0;
            r_dout_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= EDGE_OFF;
                r_active[i] <= EDGE_OFF;
            end
        end else begin
            r_dout_valid <= w_apply;
            if (w_apply) begin
                r_active   <= r_shadow;
                r_complete <= 1'b0;
            end
            if (w_wr) begin
                r_shadow[r_wr_idx] <= w_edge;
                r_wr_idx           <= w_last ? '0 : r_wr_idx + 1'b1;
                r_complete         <= w_last;
            end
        end
    end

`ifdef PWM_BANK_FRAME_CHECK_EN
    logic r_frame_err;
    logic w_underrun;
    logic w_overrun;

    assign w_underrun = UPDATE && !r_complete && r_wr_idx != '0;
    assign w_overrun  = DIN_VALID && r_complete;
    assign FRAME_ERR  = r_frame_err;

    always_ff @(posedge CLK) begin
        r_frame_err <= RST ? 1'b0 : (r_frame_err || w_underrun || w_overrun);
    end
`else
    assign FRAME_ERR = 1'b0;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_ch
        pwm_bank_channel u_ch (
            .i_clk      (CLK),
            .i_rst      (RST),
            .i_time_cnt (TIME_CNT),
            .i_edge     (r_active[g]),
            .i_en       (OUTPUT_EN),
            .o_pwm      (PWM_OUT[g])
        );
    end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed and randomized checks of pwm_bank against a pulse-window model.
module tb_pwm_bank;
    localparam int DEPTH = 249;
`ifdef PWM_BANK_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] time_cnt = '0;
    logic       upd = 1'b0;
    logic       din = 1'b0;
    logic [8:0] pw = '0;
    logic [7:0] ph = '0;
    logic       oen = 1'b1;
    logic       pwm_out [DEPTH];
    logic       dout_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int s_pw [DEPTH], s_ph [DEPTH], a_pw [DEPTH], a_ph [DEPTH];
    int f_pw [DEPTH], f_ph [DEPTH];
    int m_idx = 0;
    bit m_cpl = 1'b0;
    bit m_err = 1'b0;
    int last_t = 0;

    always #5 clk = ~clk;

    pwm_bank #(.DEPTH(DEPTH), .CNT_WIDTH(9), .PHASE_WIDTH(8)) dut (
        .CLK         (clk),
        .RST         (rst),
        .TIME_CNT    (time_cnt),
        .UPDATE      (upd),
        .DIN_VALID   (din),
        .PULSE_WIDTH (pw),
        .PHASE       (ph),
        .OUTPUT_EN   (oen),
        .PWM_OUT     (pwm_out),
        .DOUT_VALID  (dout_valid),
        .FRAME_ERR   (frame_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // High while the carrier is within pw counts after the window start centred on the phase.
    function automatic bit hi(input int w, input int p, input int t);
        int start;
        start = (p * 2 - w / 2 + 512) % 512;
        return ((t - start + 512) % 512) < w;
    endfunction

    function automatic logic [255:0] pwm_vec();
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < DEPTH; c++) v[c] = pwm_out[c];
        return v;
    endfunction

    task automatic cycle();
        logic [255:0] e_pwm;
        bit e_dv;
        bit cpl0;
        e_pwm = '0;
        for (int c = 0; c < DEPTH; c++) e_pwm[c] = !rst && oen && hi(a_pw[c], a_ph[c], int'(time_cnt));
        cpl0 = m_cpl;
        e_dv = !rst && upd && cpl0;
        if (rst) begin
            m_idx = 0;
            m_cpl = 1'b0;
            m_err = 1'b0;
            for (int c = 0; c < DEPTH; c++) begin
                s_pw[c] = 0; s_ph[c] = 0; a_pw[c] = 0; a_ph[c] = 0;
            end
        end else begin
            if (FRAME_CHECK && ((upd && !cpl0 && m_idx != 0) || (din && cpl0))) m_err = 1'b1;
            if (upd && cpl0) begin
                a_pw = s_pw;
                a_ph = s_ph;
                m_cpl = 1'b0;
            end
            if (din && !cpl0) begin
                s_pw[m_idx] = int'(pw);
                s_ph[m_idx] = int'(ph);
                m_idx++;
                if (m_idx == DEPTH) begin
                    m_idx = 0;
                    m_cpl = 1'b1;
                end
            end
        end
        last_t = int'(time_cnt);
        @(posedge clk);
        #1;
        check("pwm", pwm_vec(), e_pwm);
        check("dout_valid", dout_valid, e_dv);
        check("frame_err", frame_err, m_err);
        time_cnt = time_cnt + 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write(input int w, input int p);
        din = 1'b1;
        pw = 9'(w);
        ph = 8'(p);
        cycle();
        din = 1'b0;
    endtask

    task automatic load(input int from, input int n);
        for (int k = from; k < from + n; k++) write(f_pw[k], f_ph[k]);
    endtask

    task automatic update();
        upd = 1'b1;
        cycle();
        upd = 1'b0;
    endtask

    task automatic new_frame();
        for (int k = 0; k < DEPTH; k++) begin
            f_pw[k] = $urandom_range(0, 511);
            f_ph[k] = $urandom_range(0, 255);
        end
    endtask

    initial begin
        for (int c = 0; c < DEPTH; c++) begin
            s_pw[c] = 0; s_ph[c] = 0; a_pw[c] = 0; a_ph[c] = 0;
        end
        idle(2);
        rst = 1'b0;
        idle(2);

        new_frame();
        f_pw[0] = 256; f_ph[0] = 128;
        f_pw[1] = 100; f_ph[1] = 0;
        f_pw[2] = 0;
        f_pw[3] = 511; f_ph[3] = 0;
        load(0, DEPTH);
        idle(3);
        update();
        check("dv_pulse", dout_valid, 1'b1);
        cycle();
        check("dv_one_cycle", dout_valid, 1'b0);
        for (int i = 0; i < 513; i++) begin
            cycle();
            check("ch0_centre", pwm_out[0], last_t >= 128 && last_t < 384);
            check("ch1_wrap", pwm_out[1], last_t >= 462 || last_t < 50);
            check("ch2_zero", pwm_out[2], 1'b0);
            check("ch3_full", pwm_out[3], last_t != 256);
        end

        new_frame();
        load(0, 100);
        update();
        check("underrun_err", frame_err, FRAME_CHECK);
        check("underrun_no_dv", dout_valid, 1'b0);
        idle(64);
        load(100, DEPTH - 100);
        update();
        check("underrun_applied_dv", dout_valid, 1'b1);
        idle(512);

        new_frame();
        load(0, DEPTH);
        write(17, 33);
        check("overrun_err", frame_err, FRAME_CHECK);
        update();
        idle(512);

        new_frame();
        load(0, 50);
        rst = 1'b1;
        idle(3);
        check("rst_pwm", pwm_vec(), '0);
        check("rst_dv", dout_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
        rst = 1'b0;

        new_frame();
        load(0, DEPTH - 1);
        din = 1'b1; upd = 1'b1;
        pw = 9'(f_pw[DEPTH-1]); ph = 8'(f_ph[DEPTH-1]);
        cycle();
        din = 1'b0; upd = 1'b0;
        check("coinc_no_dv", dout_valid, 1'b0);
        idle(64);
        update();
        check("coinc_next_dv", dout_valid, 1'b1);
        idle(512);
        oen = 1'b0;
        cycle();
        check("gate_off", pwm_vec(), '0);
        idle(8);
        oen = 1'b1;
        idle(8);

        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 299) == 0;
            din = $urandom_range(0, 3) != 0;
            upd = $urandom_range(0, 149) == 0;
            oen = $urandom_range(0, 19) != 0;
            pw = 9'($urandom_range(0, 511));
            ph = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 63) == 0) time_cnt = 9'($urandom_range(0, 511));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
